traffic_monitor: RTL and testbench

//  Receive-side checker for the two-direction lamp bus (r/y/g, bit 0 = dir0, bit 1 = dir1).

---
 rtl/traffic_monitor.sv | 151 +++++++++++++++
 tb/tb_traffic_monitor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_monitor.sv
// traffic_monitor
//   Receive-side checker for a two-direction lamp bus (bit 0 = dir0, bit 1 = dir1).
//   The monitor decodes each lamp sample into one of four phases and locks onto
//   the phase sequence P0 -> P1 -> P2 -> P3 -> P0. It also times every phase and
//   flags illegal lamp codes, out-of-order phases and wrong phase durations.
//   Every output is registered and reflects the sample taken at the previous
//   posedge.
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   r, y, g      red / yellow / green lamps, [dir1:dir0]
//   phase        last legally decoded phase (holds across illegal samples)
//   phase_valid  last sample was a legal code
//   run_cnt      consecutive samples of the current phase, saturating
//   locked       sequence tracking active
//   err_illegal  pulse: illegal lamp code
//   err_seq      pulse: legal phase change to the wrong next phase
//   err_timing   pulse: phase ended early or overran its length
//   err_sticky   OR of all error pulses since reset
//   cycles       completed P3->P0 transitions while locked, saturating
module traffic_monitor #(
  parameter int GREEN_LEN  = 6,
  parameter int YELLOW_LEN = 2,
  parameter int CNT_W      = 4,
  parameter int CYC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       r,
  input  logic [1:0]       y,
  input  logic [1:0]       g,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] run_cnt,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_timing,
  output logic             err_sticky,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic {SYNC, LOCKED} state_t;

  localparam logic [CNT_W:0] GLEN = (CNT_W+1)'(GREEN_LEN);
  localparam logic [CNT_W:0] YLEN = (CNT_W+1)'(YELLOW_LEN);

  state_t           state, state_nx;
  logic [1:0]       cur;
  logic             cur_legal;
  logic [1:0]       phase_succ;
  logic [CNT_W:0]   prev_len;
  logic [CNT_W:0]   run_inc;
  logic [1:0]       phase_nx;
  logic             valid_nx;
  logic [CNT_W-1:0] run_nx;
  logic             ill_nx, seq_nx, tim_nx, sticky_nx;
  logic [CYC_W-1:0] cyc_nx;

  always_comb begin
    cur       = '0;
    cur_legal = 1'b1;
    case ({r, y, g})
      6'b01_00_10: cur = 2'd0;
      6'b01_10_00: cur = 2'd1;
      6'b10_00_01: cur = 2'd2;
      6'b10_01_00: cur = 2'd3;
      default:     cur_legal = 1'b0;
    endcase
  end

  // Odd phases are yellow, even phases are green.
  assign prev_len   = phase[0] ? YLEN : GLEN;
  assign phase_succ = phase + 2'd1;
  // One bit wider than run_cnt so an overrun compare is never hidden by wrap.
  assign run_inc    = {1'b0, run_cnt} + (CNT_W+1)'(1);
  assign locked     = (state == LOCKED);

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    valid_nx = phase_valid;
    run_nx   = run_cnt;
    ill_nx   = 1'b0;
    seq_nx   = 1'b0;
    tim_nx   = 1'b0;
    cyc_nx   = cycles;
    if (!cur_legal) begin
      ill_nx   = 1'b1;
      valid_nx = 1'b0;
      run_nx   = '0;
      state_nx = SYNC;
    end else begin
      phase_nx = cur;
      valid_nx = 1'b1;
      if (phase_valid && cur == phase)
        run_nx = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
      else
        run_nx = CNT_W'(1);
      if (state == SYNC) begin
        if (phase_valid && cur == phase_succ)
          state_nx = LOCKED;
      end else begin
        if (cur == phase) begin
          if (run_inc > prev_len) begin
            tim_nx   = 1'b1;
            state_nx = SYNC;
          end
        end else if (cur == phase_succ) begin
          if ({1'b0, run_cnt} != prev_len) begin
            tim_nx   = 1'b1;
            state_nx = SYNC;
          end else if (phase == 2'd3 && cycles != '1) begin
            cyc_nx = cycles + CYC_W'(1);
          end
        end else begin
          seq_nx   = 1'b1;
          state_nx = SYNC;
        end
      end
    end
    sticky_nx = err_sticky | ill_nx | seq_nx | tim_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= '0;
      phase_valid <= 1'b0;
      run_cnt     <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_timing  <= 1'b0;
      err_sticky  <= 1'b0;
      cycles      <= '0;
    end else begin
      phase       <= phase_nx;
      phase_valid <= valid_nx;
      run_cnt     <= run_nx;
      err_illegal <= ill_nx;
      err_seq     <= seq_nx;
      err_timing  <= tim_nx;
      err_sticky  <= sticky_nx;
      cycles      <= cyc_nx;
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Testbench for traffic_monitor: table-driven vectors, directed corner-case
// sequences and randomized lamp traffic checked against a phase-level model.
module tb_traffic_monitor;
  localparam int GREEN_LEN  = 6;
  localparam int YELLOW_LEN = 2;
  localparam int CNT_W      = 4;
  localparam int CYC_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int CYC_MAX    = (1 << CYC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       r, y, g;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] run_cnt;
  logic             locked;
  logic             err_illegal, err_seq, err_timing, err_sticky;
  logic [CYC_W-1:0] cycles;

  traffic_monitor #(
    .GREEN_LEN (GREEN_LEN),
    .YELLOW_LEN(YELLOW_LEN),
    .CNT_W     (CNT_W),
    .CYC_W     (CYC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .r          (r),
    .y          (y),
    .g          (g),
    .phase      (phase),
    .phase_valid(phase_valid),
    .run_cnt    (run_cnt),
    .locked     (locked),
    .err_illegal(err_illegal),
    .err_seq    (err_seq),
    .err_timing (err_timing),
    .err_sticky (err_sticky),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // {r, y, g} lamp codes of P0..P3
  logic [5:0] codes [4] = '{6'b01_00_10, 6'b01_10_00, 6'b10_00_01, 6'b10_01_00};
  localparam logic [5:0] ILL = 6'b11_00_00;

  // Phase-level reference model
  int m_phase, m_run, m_cycles;
  bit m_valid, m_locked, m_ill, m_seq, m_tim, m_sticky;

  function automatic int plen(input int k);
    return (k % 2 == 0) ? GREEN_LEN : YELLOW_LEN;
  endfunction

  function automatic int decode(input logic [5:0] c);
    for (int i = 0; i < 4; i++)
      if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_cycles = 0;
    m_valid = 0; m_locked = 0; m_ill = 0; m_seq = 0; m_tim = 0; m_sticky = 0;
  endtask

  task automatic model_step(input logic [5:0] c);
    int k, p, rc, nx;
    bit v;
    k = decode(c); p = m_phase; rc = m_run; v = m_valid; nx = (p + 1) % 4;
    m_ill = 0; m_seq = 0; m_tim = 0;
    if (k < 0) begin
      m_ill = 1; m_valid = 0; m_run = 0; m_locked = 0;
    end else begin
      if (!m_locked) begin
        if (v && k == nx) m_locked = 1;
      end else if (k == p) begin
        if (rc + 1 > plen(p)) begin m_tim = 1; m_locked = 0; end
      end else if (k == nx) begin
        if (rc != plen(p)) begin m_tim = 1; m_locked = 0; end
        else if (p == 3 && m_cycles < CYC_MAX) m_cycles++;
      end else begin
        m_seq = 1; m_locked = 0;
      end
      m_run   = (v && k == p) ? ((rc < CNT_MAX) ? rc + 1 : rc) : 1;
      m_phase = k;
      m_valid = 1;
    end
    if (m_ill || m_seq || m_tim) m_sticky = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".phase"},       32'(phase),       32'(m_phase));
    chk({tag, ".phase_valid"}, 32'(phase_valid), 32'(m_valid));
    chk({tag, ".run_cnt"},     32'(run_cnt),     32'(m_run));
    chk({tag, ".locked"},      32'(locked),      32'(m_locked));
    chk({tag, ".err_illegal"}, 32'(err_illegal), 32'(m_ill));
    chk({tag, ".err_seq"},     32'(err_seq),     32'(m_seq));
    chk({tag, ".err_timing"},  32'(err_timing),  32'(m_tim));
    chk({tag, ".err_sticky"},  32'(err_sticky),  32'(m_sticky));
    chk({tag, ".cycles"},      32'(cycles),      32'(m_cycles));
  endtask

  task automatic step(input logic [5:0] c, input string tag);
    {r, y, g} = c;
    @(posedge clk);
    model_step(c);
    #1;
    check_model(tag);
  endtask

  task automatic send(input int k, input int n, input string tag);
    repeat (n) step(codes[k], tag);
  endtask

  task automatic run_loops(input int n, input string tag);
    repeat (n) begin
      send(0, GREEN_LEN, tag);
      send(1, YELLOW_LEN, tag);
      send(2, GREEN_LEN, tag);
      send(3, YELLOW_LEN, tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {r, y, g} = '0;
    #3;
    model_reset();
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] code;
    int         rep;
    int         ph;
    bit         v;
    int         run;
    bit         lk;
    bit         ill;
    bit         stk;
    int         cyc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [5:0] c;
    int k, len;

    rst = 1'b1;
    {r, y, g} = '0;
    model_reset();

    // code, rep, phase, valid, run_cnt, locked, err_illegal, err_sticky, cycles
    tbl.push_back('{codes[0], 6, 0, 1, 6, 0, 0, 0, 0});
    tbl.push_back('{codes[1], 1, 1, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{codes[1], 1, 1, 1, 2, 1, 0, 0, 0});
    tbl.push_back('{codes[2], 6, 2, 1, 6, 1, 0, 0, 0});
    tbl.push_back('{codes[3], 2, 3, 1, 2, 1, 0, 0, 0});
    tbl.push_back('{codes[0], 1, 0, 1, 1, 1, 0, 0, 1});
    tbl.push_back('{codes[0], 5, 0, 1, 6, 1, 0, 0, 1});
    tbl.push_back('{codes[1], 2, 1, 1, 2, 1, 0, 0, 1});
    tbl.push_back('{codes[2], 6, 2, 1, 6, 1, 0, 0, 1});
    tbl.push_back('{codes[3], 2, 3, 1, 2, 1, 0, 0, 1});
    tbl.push_back('{codes[0], 1, 0, 1, 1, 1, 0, 0, 2});
    tbl.push_back('{ILL,      1, 0, 0, 0, 0, 1, 1, 2});
    tbl.push_back('{codes[0], 1, 0, 1, 1, 0, 0, 1, 2});
    tbl.push_back('{codes[0], 5, 0, 1, 6, 0, 0, 1, 2});
    tbl.push_back('{codes[1], 1, 1, 1, 1, 1, 0, 1, 2});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].rep) step(tbl[i].code, "tbl");
      chk($sformatf("tbl[%0d].phase", i),       32'(phase),       32'(tbl[i].ph));
      chk($sformatf("tbl[%0d].phase_valid", i), 32'(phase_valid), 32'(tbl[i].v));
      chk($sformatf("tbl[%0d].run_cnt", i),     32'(run_cnt),     32'(tbl[i].run));
      chk($sformatf("tbl[%0d].locked", i),      32'(locked),      32'(tbl[i].lk));
      chk($sformatf("tbl[%0d].err_illegal", i), 32'(err_illegal), 32'(tbl[i].ill));
      chk($sformatf("tbl[%0d].err_seq", i),     32'(err_seq),     32'(0));
      chk($sformatf("tbl[%0d].err_timing", i),  32'(err_timing),  32'(0));
      chk($sformatf("tbl[%0d].err_sticky", i),  32'(err_sticky),  32'(tbl[i].stk));
      chk($sformatf("tbl[%0d].cycles", i),      32'(cycles),      32'(tbl[i].cyc));
    end

    // Legal loop from reset: lock on the 7th edge, three more loops -> cycles=3
    do_reset();
    send(0, 6, "t1");
    chk("t1.unlocked_p0", 32'(locked), 32'(0));
    send(1, 1, "t1");
    chk("t1.lock_at_p1", 32'(locked), 32'(1));
    send(1, 1, "t1"); send(2, 6, "t1"); send(3, 2, "t1");
    run_loops(3, "t1");
    chk("t1.cycles", 32'(cycles), 32'(3));
    chk("t1.sticky", 32'(err_sticky), 32'(0));

    // Illegal code while locked, then relock
    step(ILL, "t2");
    chk("t2.err_illegal", 32'(err_illegal), 32'(1));
    chk("t2.valid", 32'(phase_valid), 32'(0));
    chk("t2.run_cnt", 32'(run_cnt), 32'(0));
    chk("t2.locked", 32'(locked), 32'(0));
    chk("t2.sticky", 32'(err_sticky), 32'(1));
    send(0, 6, "t2");
    chk("t2.still_sync", 32'(locked), 32'(0));
    send(1, 1, "t2");
    chk("t2.relock", 32'(locked), 32'(1));

    // Green overrun, then P1 x4
    send(1, 1, "t3"); send(2, 6, "t3"); send(3, 2, "t3"); send(0, 6, "t3");
    chk("t3.locked_p0x6", 32'(locked), 32'(1));
    send(0, 1, "t3");
    chk("t3.overrun", 32'(err_timing), 32'(1));
    chk("t3.unlocked", 32'(locked), 32'(0));
    send(1, 1, "t3");
    chk("t3.relock", 32'(locked), 32'(1));
    chk("t3.no_tim_relock", 32'(err_timing), 32'(0));
    send(1, 2, "t3");
    send(1, 1, "t3");
    chk("t3.no_tim_sync", 32'(err_timing), 32'(0));

    // Wrong successor after a full P2
    send(2, 6, "t4"); send(3, 2, "t4"); send(0, 6, "t4"); send(1, 2, "t4"); send(2, 6, "t4");
    chk("t4.locked", 32'(locked), 32'(1));
    send(0, 1, "t4");
    chk("t4.err_seq", 32'(err_seq), 32'(1));
    chk("t4.no_timing", 32'(err_timing), 32'(0));
    chk("t4.unlocked", 32'(locked), 32'(0));

    // Short P3 -> early end, cycles unchanged
    send(1, 2, "t5"); send(2, 6, "t5"); send(3, 1, "t5");
    chk("t5.locked", 32'(locked), 32'(1));
    send(0, 1, "t5");
    chk("t5.err_timing", 32'(err_timing), 32'(1));
    chk("t5.cycles", 32'(cycles), 32'(5));

    // Asynchronous reset mid-P2 with cycles=5
    do_reset();
    run_loops(5, "t6");
    send(0, 6, "t6"); send(1, 2, "t6"); send(2, 3, "t6");
    chk("t6.cycles_before", 32'(cycles), 32'(5));
    chk("t6.locked_before", 32'(locked), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6.async_cycles", 32'(cycles), 32'(0));
    chk("t6.async_locked", 32'(locked), 32'(0));
    chk("t6.async_run", 32'(run_cnt), 32'(0));
    chk("t6.async_valid", 32'(phase_valid), 32'(0));
    check_model("t6.async");
    @(negedge clk);
    rst = 1'b0;
    send(0, 6, "t6");
    chk("t6.sync", 32'(locked), 32'(0));
    send(1, 1, "t6");
    chk("t6.relock", 32'(locked), 32'(1));

    // run_cnt saturation (SYNC, long hold)
    send(0, 20, "sat_run");
    chk("sat_run.run_cnt", 32'(run_cnt), 32'(CNT_MAX));

    // cycles saturation
    do_reset();
    run_loops(260, "sat_cyc");
    chk("sat_cyc.cycles", 32'(cycles), 32'(CYC_MAX));

    // Randomized traffic against the model
    do_reset();
    k = 0;
    repeat (400) begin
      if ($urandom_range(0, 99) < 5) begin
        do c = 6'($urandom); while (decode(c) >= 0);
        step(c, "rand");
      end
      len = ($urandom_range(0, 9) < 8) ? plen(k) : int'($urandom_range(1, 9));
      send(k, len, "rand");
      k = ($urandom_range(0, 9) < 9) ? (k + 1) % 4 : int'($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
